// File: rtl/alu_bcd_seq_if.sv
// Request/response bundle for alu_bcd_seq: operand request with valid/ready
// handshake on one side, result plus C/Z/V/N flags with valid/ready on the other.
interface alu_bcd_seq_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic             i_dec;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_c;
  logic             o_z;
  logic             o_v;
  logic             o_n;

  // Requester / result consumer side
  modport master (
    output i_valid, i_op, i_dec, i_a, i_b, i_cin, i_ready,
    input  o_ready, o_valid, o_result, o_c, o_z, o_v, o_n
  );

  // ALU side
  modport slave (
    input  i_valid, i_op, i_dec, i_a, i_b, i_cin, i_ready,
    output o_ready, o_valid, o_result, o_c, o_z, o_v, o_n
  );
endinterface

// File: rtl/alu_bcd_seq.sv
// Handshaked 6502-style ALU. Binary ops finish in the accept cycle; decimal
// SUM/SUB are corrected one BCD digit per cycle, least significant digit first.
// WIDTH must be a multiple of 4 and at least 4.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no operation held, ready for a request
// DEC    | decimal op in progress, one digit corrected per cycle
// DONE   | result and flags valid, held until the consumer takes them
module alu_bcd_seq #(
  parameter int WIDTH = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_bcd_seq_if.slave bus
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);

  localparam logic [2:0] OP_SUM  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_EOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;
  localparam logic [2:0] OP_SL   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             ready_int;
  logic             accept;
  logic             req_dec;
  logic             single_digit;

  // binary datapath (operates directly on the request)
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             arith_v;
  logic [WIDTH-1:0] bin_r;
  logic             bin_c;
  logic             bin_v;

  // decimal datapath
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             carry_q, dsub_q, v_q;
  logic [CW-1:0]    cnt;
  logic [3:0]       dig_a, dig_b, dig_d;
  logic             dig_cin, dig_sub, dig_c;
  logic [4:0]       sum5;
  logic [5:0]       diff6;
  logic [WIDTH-1:0] acc_nxt;

  // result commit
  logic             commit;
  logic [WIDTH-1:0] commit_r;
  logic             commit_c, commit_v;

  logic [WIDTH-1:0] result_q;
  logic             c_q, z_q, v_out_q, n_q;

  assign single_digit = (DIGITS == 1);
  assign req_dec      = bus.i_dec & ((bus.i_op == OP_SUM) | (bus.i_op == OP_SUB));
  assign ready_int    = (state == S_IDLE) | ((state == S_DONE) & bus.i_ready);
  assign accept       = bus.i_valid & ready_int;

  // Binary ALU and the signed overflow of SUM/SUB, which decimal ops also report
  always_comb begin
    b_eff    = (bus.i_op == OP_SUB) ? ~bus.i_b : bus.i_b;
    sum_full = {1'b0, bus.i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.i_cin};
    arith_v  = (bus.i_a[WIDTH-1] == b_eff[WIDTH-1]) &
               (sum_full[WIDTH-1] != bus.i_a[WIDTH-1]);
    bin_r    = bus.i_a;
    bin_c    = bus.i_cin;
    bin_v    = 1'b0;
    case (bus.i_op)
      OP_SUM, OP_SUB: begin
        bin_r = sum_full[WIDTH-1:0];
        bin_c = sum_full[WIDTH];
        bin_v = arith_v;
      end
      OP_AND: bin_r = bus.i_a & bus.i_b;
      OP_OR:  bin_r = bus.i_a | bus.i_b;
      OP_EOR: bin_r = bus.i_a ^ bus.i_b;
      OP_SR: begin
        bin_r = {bus.i_cin, bus.i_a[WIDTH-1:1]};
        bin_c = bus.i_a[0];
      end
      OP_SL: begin
        bin_r = {bus.i_a[WIDTH-2:0], bus.i_cin};
        bin_c = bus.i_a[WIDTH-1];
      end
      default: bin_r = bus.i_a;
    endcase
  end

  // One-digit BCD corrector; the first digit is taken straight from the request
  // in the accept cycle so a decimal result lands DIGITS cycles after accept
  always_comb begin
    if (state == S_DEC) begin
      dig_a   = a_sh[3:0];
      dig_b   = b_sh[3:0];
      dig_cin = carry_q;
      dig_sub = dsub_q;
    end else begin
      dig_a   = bus.i_a[3:0];
      dig_b   = bus.i_b[3:0];
      dig_cin = bus.i_cin;
      dig_sub = (bus.i_op == OP_SUB);
    end
    sum5  = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, dig_cin};
    diff6 = {2'b0, dig_a} - {2'b0, dig_b} - {5'b0, ~dig_cin};
    dig_d = sum5[3:0];
    dig_c = 1'b0;
    if (dig_sub) begin
      if (diff6[5]) begin
        dig_d = diff6[3:0] + 4'd10;
        dig_c = 1'b0;
      end else begin
        dig_d = diff6[3:0];
        dig_c = 1'b1;
      end
    end else if (sum5 > 5'd9) begin
      dig_d = sum5[3:0] + 4'd6;
      dig_c = 1'b1;
    end
    acc_nxt = (acc >> 4) | (WIDTH'(dig_d) << (WIDTH - 4));
  end

  // Next state, handshake outputs and result commit selection
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    commit_r  = bin_r;
    commit_c  = bin_c;
    commit_v  = bin_v;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!req_dec) begin
            commit    = 1'b1;
            state_nxt = S_DONE;
          end else if (single_digit) begin
            commit    = 1'b1;
            commit_r  = acc_nxt;
            commit_c  = dig_c;
            commit_v  = arith_v;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DEC;
          end
        end else if (state == S_DONE && bus.i_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_DEC: begin
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          commit_r  = acc_nxt;
          commit_c  = dig_c;
          commit_v  = v_q;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Decimal working registers: operands shift right one digit per cycle,
  // corrected digits shift into the top of acc; cnt counts digits left
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      dsub_q  <= 1'b0;
      v_q     <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= bus.i_a >> 4;
      b_sh    <= bus.i_b >> 4;
      acc     <= acc_nxt;
      carry_q <= dig_c;
      dsub_q  <= (bus.i_op == OP_SUB);
      v_q     <= arith_v;
      cnt     <= CW'(DIGITS - 1);
    end else if (state == S_DEC) begin
      a_sh    <= a_sh >> 4;
      b_sh    <= b_sh >> 4;
      acc     <= acc_nxt;
      carry_q <= dig_c;
      cnt     <= cnt - CW'(1);
    end
  end

  // Result and flags change only when a result is committed into DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_out_q  <= 1'b0;
      n_q      <= 1'b0;
    end else if (commit) begin
      result_q <= commit_r;
      c_q      <= commit_c;
      z_q      <= (commit_r == '0);
      v_out_q  <= commit_v;
      n_q      <= commit_r[WIDTH-1];
    end
  end

  // o_ready is forced low while reset is held
  assign bus.o_ready  = i_rst_n & ready_int;
  assign bus.o_valid  = (state == S_DONE);
  assign bus.o_result = result_q;
  assign bus.o_c      = c_q;
  assign bus.o_z      = z_q;
  assign bus.o_v      = v_out_q;
  assign bus.o_n      = n_q;

endmodule

// File: tb/tb_alu_bcd_seq.sv
// Bench for alu_bcd_seq: WIDTH=8 and WIDTH=16 instances, directed vector table,
// backpressure and mid-op reset sequences, then random ops against a model.
module tb_alu_bcd_seq;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_bcd_seq_if #(.WIDTH(8))  if8 ();
  alu_bcd_seq_if #(.WIDTH(16)) if16 ();

  alu_bcd_seq #(.WIDTH(8))  dut8  (.i_clk(i_clk), .i_rst_n(rst_n), .bus(if8));
  alu_bcd_seq #(.WIDTH(16)) dut16 (.i_clk(i_clk), .i_rst_n(rst_n), .bus(if16));

  always #5 i_clk = ~i_clk;

  typedef struct {
    int w, op, dec, a, b, cin;
    int r, c, z, v, n, lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit vld, input int op, input int dec,
                       input int a, input int b, input int cin);
    if (w == 8) begin
      if8.i_valid = vld;
      if8.i_op    = 3'(op);
      if8.i_dec   = dec[0];
      if8.i_a     = 8'(a);
      if8.i_b     = 8'(b);
      if8.i_cin   = cin[0];
    end else begin
      if16.i_valid = vld;
      if16.i_op    = 3'(op);
      if16.i_dec   = dec[0];
      if16.i_a     = 16'(a);
      if16.i_b     = 16'(b);
      if16.i_cin   = cin[0];
    end
  endtask

  task automatic read_out(input int w, output logic [31:0] r, output logic c,
                          output logic z, output logic v, output logic n,
                          output logic vld, output logic rdy);
    if (w == 8) begin
      r = {24'b0, if8.o_result};
      c = if8.o_c; z = if8.o_z; v = if8.o_v; n = if8.o_n;
      vld = if8.o_valid; rdy = if8.o_ready;
    end else begin
      r = {16'b0, if16.o_result};
      c = if16.o_c; z = if16.o_z; v = if16.o_v; n = if16.o_n;
      vld = if16.o_valid; rdy = if16.o_ready;
    end
  endtask

  // Reference: plain integer arithmetic, digit-by-digit decimal rules
  function automatic void model(input int w, input int op, input int dec,
                                input int a, input int b, input int cin,
                                output int r, output int c, output int z,
                                output int v, output int n, output int lat);
    int mask, half, be, full, sa, sb, ss, carry, s, ad, bd;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    r = 0; c = cin; v = 0; lat = 1;
    if (op <= 1) begin
      be   = (op == 1) ? (~b & mask) : b;
      full = a + be + cin;
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (be >= half) ? be - (1 << w) : be;
      ss   = sa + sb + cin;
      v    = (ss >= half || ss < -half) ? 1 : 0;
      if (dec != 0) begin
        lat   = w / 4;
        carry = cin;
        for (int k = 0; k < w / 4; k++) begin
          ad = (a >> (4 * k)) & 15;
          bd = (b >> (4 * k)) & 15;
          if (op == 0) begin
            s = ad + bd + carry;
            if (s > 9) begin s = s + 6; carry = 1; end
            else carry = 0;
          end else begin
            s = ad - bd - (1 - carry);
            if (s < 0) begin s = s + 10; carry = 0; end
            else carry = 1;
          end
          r = r | ((s & 15) << (4 * k));
        end
        c = carry;
      end else begin
        r = full & mask;
        c = (full >> w) & 1;
      end
    end else begin
      case (op)
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: begin r = (cin << (w - 1)) | (a >> 1); c = a & 1; end
        6: begin r = ((a << 1) | cin) & mask; c = (a >> (w - 1)) & 1; end
        default: r = a;
      endcase
    end
    z = (r == 0) ? 1 : 0;
    n = (r >> (w - 1)) & 1;
  endfunction

  // Issue one request (called just after a rising edge), return the result,
  // the accept-to-valid latency and whether o_ready was seen high while busy
  task automatic run_op(input int w, input int op, input int dec, input int a,
                        input int b, input int cin, output logic [31:0] r,
                        output logic c, output logic z, output logic v,
                        output logic n, output int lat, output int rdy_busy);
    logic vld, rdy;
    drive(w, 1'b1, op, dec, a, b, cin);
    #1;
    read_out(w, r, c, z, v, n, vld, rdy);
    for (int t = 0; t < 20 && rdy !== 1'b1; t++) begin
      @(posedge i_clk); #1;
      read_out(w, r, c, z, v, n, vld, rdy);
    end
    chk("accept_ready", rdy, 1);
    @(posedge i_clk); #1;
    drive(w, 1'b0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1));
    lat = 1;
    rdy_busy = 0;
    read_out(w, r, c, z, v, n, vld, rdy);
    while (vld !== 1'b1 && lat < 40) begin
      if (rdy === 1'b1) rdy_busy = 1;
      @(posedge i_clk); #1;
      lat++;
      read_out(w, r, c, z, v, n, vld, rdy);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic c, z, v, n, vld, rdy;
    int lat, rdy_busy;
    int er, ec, ez, ev, en, elat, w, op, dec, a, b, cin, mask;

    //          w  op dec a        b        cin r        c  z  v  n  lat
    vecs[0]  = '{8,  0, 0, 'h7F,   'h01,   0, 'h80,   0, 0, 1, 1, 1};
    vecs[1]  = '{8,  0, 1, 'h58,   'h46,   1, 'h05,   1, 0, 1, 0, 2};
    vecs[2]  = '{8,  1, 1, 'h12,   'h21,   1, 'h91,   0, 0, 0, 1, 2};
    vecs[3]  = '{16, 0, 1, 'h9999, 'h0001, 0, 'h0000, 1, 1, 0, 0, 4};
    vecs[4]  = '{8,  5, 0, 'h81,   'h00,   1, 'hC0,   1, 0, 0, 1, 1};
    vecs[5]  = '{8,  6, 0, 'h80,   'h00,   0, 'h00,   1, 1, 0, 0, 1};
    vecs[6]  = '{8,  2, 0, 'hF0,   'h3C,   1, 'h30,   1, 0, 0, 0, 1};
    vecs[7]  = '{8,  3, 0, 'h0F,   'hA0,   0, 'hAF,   0, 0, 0, 1, 1};
    vecs[8]  = '{8,  4, 0, 'hFF,   'h0F,   0, 'hF0,   0, 0, 0, 1, 1};
    vecs[9]  = '{8,  7, 1, 'h00,   'h55,   1, 'h00,   1, 1, 0, 0, 1};
    vecs[10] = '{8,  1, 0, 'h50,   'hB0,   1, 'hA0,   0, 0, 1, 1, 1};
    vecs[11] = '{16, 0, 0, 'h0001, 'h0001, 0, 'h0002, 0, 0, 0, 0, 1};
    vecs[12] = '{8,  0, 1, 'h99,   'h01,   0, 'h00,   1, 1, 0, 0, 2};
    vecs[13] = '{16, 1, 1, 'h1000, 'h0001, 1, 'h0999, 1, 0, 0, 0, 4};
    vecs[14] = '{16, 1, 1, 'h0000, 'h0001, 1, 'h9999, 0, 0, 0, 1, 4};
    vecs[15] = '{8,  2, 1, 'hAA,   'h0F,   0, 'h0A,   0, 0, 0, 0, 1};

    drive(8, 1'b0, 0, 0, 0, 0, 0);
    drive(16, 1'b0, 0, 0, 0, 0, 0);
    if8.i_ready  = 1'b1;
    if16.i_ready = 1'b1;

    // reset state
    #22;
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("rst8_valid", vld, 0);  chk("rst8_ready", rdy, 0);
    chk("rst8_result", r, 0);   chk("rst8_flags", {c, z, v, n}, 0);
    read_out(16, r, c, z, v, n, vld, rdy);
    chk("rst16_valid", vld, 0); chk("rst16_ready", rdy, 0);
    chk("rst16_result", r, 0);  chk("rst16_flags", {c, z, v, n}, 0);
    rst_n = 1'b1;
    @(posedge i_clk); #1;
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("post_rst8_ready", rdy, 1);

    // directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].op, vecs[i].dec, vecs[i].a, vecs[i].b, vecs[i].cin,
             r, c, z, v, n, lat, rdy_busy);
      chk($sformatf("vec%0d_result", i), r, vecs[i].r);
      chk($sformatf("vec%0d_czvn", i), {c, z, v, n},
          {vecs[i].c[0], vecs[i].z[0], vecs[i].v[0], vecs[i].n[0]});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) chk($sformatf("vec%0d_ready_busy", i), rdy_busy, 0);
    end

    // backpressure: result held while i_ready=0, then back-to-back accept
    @(posedge i_clk); #1;
    if8.i_ready = 1'b0;
    run_op(8, 0, 0, 'h7F, 'h01, 0, r, c, z, v, n, lat, rdy_busy);
    chk("bp_first_result", r, 'h80);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      read_out(8, r, c, z, v, n, vld, rdy);
      chk($sformatf("bp_hold%0d_valid", k), vld, 1);
      chk($sformatf("bp_hold%0d_result", k), r, 'h80);
      chk($sformatf("bp_hold%0d_czvn", k), {c, z, v, n}, 4'b0011);
      chk($sformatf("bp_hold%0d_ready", k), rdy, 0);
    end
    drive(8, 1'b1, 4, 0, 'hFF, 'h0F, 0);
    if8.i_ready = 1'b1;
    #1;
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("bp_release_ready", rdy, 1);
    @(posedge i_clk); #1;
    drive(8, 1'b0, 0, 0, 0, 0, 0);
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("b2b_valid", vld, 1);
    chk("b2b_result", r, 'hF0);
    chk("b2b_czvn", {c, z, v, n}, 4'b0001);
    @(posedge i_clk); #1;
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("b2b_drop_valid", vld, 0);

    // reset in the middle of a 16-bit decimal op
    run_op(16, 0, 1, 'h1234, 'h1111, 0, r, c, z, v, n, lat, rdy_busy);
    chk("pre_rst_result", r, 'h2345);
    @(posedge i_clk); #1;
    drive(16, 1'b1, 0, 1, 'h9999, 'h0001, 0);
    @(posedge i_clk); #1;
    drive(16, 1'b0, 0, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    read_out(16, r, c, z, v, n, vld, rdy);
    chk("mid_dec_valid", vld, 0);
    chk("mid_dec_ready", rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    read_out(16, r, c, z, v, n, vld, rdy);
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_result", r, 0);
    chk("mid_rst_flags", {c, z, v, n}, 0);
    chk("mid_rst_ready", rdy, 0);
    read_out(8, r, c, z, v, n, vld, rdy);
    chk("mid_rst_ready8", rdy, 0);
    #10 rst_n = 1'b1;
    @(posedge i_clk); #1;
    read_out(16, r, c, z, v, n, vld, rdy);
    chk("after_rst_ready", rdy, 1);
    chk("after_rst_valid", vld, 0);
    run_op(16, 0, 0, 'h0001, 'h0001, 0, r, c, z, v, n, lat, rdy_busy);
    chk("after_rst_result", r, 'h0002);
    chk("after_rst_latency", lat, 1);

    // random ops against the model
    for (int i = 0; i < 150; i++) begin
      w    = ($urandom_range(0, 1) == 1) ? 16 : 8;
      mask = (1 << w) - 1;
      op   = $urandom_range(0, 7);
      dec  = $urandom_range(0, 1);
      a    = $urandom & mask;
      b    = $urandom & mask;
      cin  = $urandom_range(0, 1);
      model(w, op, dec, a, b, cin, er, ec, ez, ev, en, elat);
      run_op(w, op, dec, a, b, cin, r, c, z, v, n, lat, rdy_busy);
      chk($sformatf("rnd%0d_w%0d_op%0d_dec%0d_result", i, w, op, dec), r, er);
      chk($sformatf("rnd%0d_czvn", i), {c, z, v, n}, {ec[0], ez[0], ev[0], en[0]});
      chk($sformatf("rnd%0d_latency", i), lat, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
